dnn_fc_layer_seq: RTL and testbench
===================================

Name: dnn_fc_layer_seq

Overview:
- Parametrised, time-multiplexed fully-connected DNN layer: N_IN inputs, N_OUT neurons, one signed MAC per clock.
- Successor to the fixed 4-4-2 datapath. Sized at elaboration, with valid/ready handshakes on both sides, a runtime-writable weight store and a selectable ReLU mode.
- Layers cascade directly (out_* of one to in_* of the next) to build deeper networks.

Parameters:
- N_IN, 4, inputs per neuron (>=1)
- N_OUT, 4, neurons in the layer (>=1)
- IN_W, 5, signed input element width
- W_W, 5, signed weight width
- ACC_W, IN_W+W_W+$clog2(N_IN), accumulator width (default 12)
- OUT_W, ACC_W, signed output element width
- RELU, 1, 1 = clamp negative results to 0; 0 = linear output

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- w_we  in  1  weight write strobe
- w_addr  in  $clog2(N_IN*N_OUT)  weight index = j*N_IN + i (neuron j, input i)
- w_data  in  W_W  signed weight value
- in_valid  in  1  input vector valid
- in_ready  out  1  layer can accept a vector
- in_data  in  N_IN*IN_W  packed inputs; element i at [i*IN_W +: IN_W]
- out_valid  out  1  result vector valid
- out_ready  in  1  downstream accepts result
- out_data  out  N_OUT*OUT_W  packed results; neuron j at [j*OUT_W +: OUT_W]
- busy  out  1  high in MAC or DONE

Behaviour:
- Clock is clk; reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0.
  - Accumulator, indices and input latch cleared; all weights 0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data, set i=0, j=0, acc=0, go to MAC.
- FSM MAC:
  - Each cycle: acc += x[i]*w[j*N_IN+i], full signed arithmetic, product sign-extended to ACC_W.
  - When i==N_IN-1:
    - Store f(acc + last product) into result j, where f = ReLU if RELU=1, else identity.
    - Reduce to OUT_W (see Optional Feature); clear acc; i=0.
    - If j==N_OUT-1 go to DONE, else j++.
  - Otherwise i++.
- FSM DONE:
  - out_valid=1; out_data held stable.
  - On out_ready go to IDLE; out_valid drops next cycle.
- Latency:
  - out_valid rises exactly N_IN*N_OUT rising edges after the accepting edge.
  - Throughput: one vector per N_IN*N_OUT+2 cycles minimum.
  - in_ready is low in MAC and DONE; in_valid is ignored there.
- Weights:
  - Written on a clk edge when w_we=1 and state==IDLE.
  - w_we is ignored in MAC and DONE, so no mid-computation change is possible.
  - w_addr >= N_IN*N_OUT is ignored.
  - A write and an accept in the same IDLE cycle: the write lands first, so the new weight is used.
- out_data:
  - Updates per neuron during MAC.
  - Defined only while out_valid=1, and stable for the whole time out_valid=1.
- Reset mid-operation: immediate return to reset values; the partial result is discarded and weights are cleared.
- Accumulator wrap: ACC_W is sized so N_IN worst-case products cannot overflow, so no wrap is possible internally.

Optional Feature:
- Macro: DNN_FC_LAYER_SAT_EN
- Defined: each result (post-ReLU) saturates to signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1] when OUT_W < ACC_W.
- Undefined: result truncates to its low OUT_W bits (wraps).
- OUT_W >= ACC_W: sign-extension, and both builds are identical.

Test Plan:
- Defaults, all weights 1, x=(1,2,3,4) → all four out_data elements = 10; out_valid high exactly 16 edges after accept; busy high throughout.
- Weights of neuron 0 all -1, others 1, x=(1,2,3,4); RELU=1 → out0=0, others 10. Same with RELU=0 → out0=-10 (0xFF6 in 12 bits).
- Corner values, x all -16, w all -16 → every out=1024. x all -16, w all 15, RELU=0 → every out=-960.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid plus w_we meanwhile → out_data unchanged, in_ready=0, weights unchanged; one cycle after out_ready=1, in_ready=1.
- Reset mid-MAC: assert rst at MAC cycle 7 → out_valid=0, busy=0 asynchronously; after release in_ready=1; a new vector with no weight writes gives all outputs 0.
- OUT_W=8, x and w all -16 (1024):
  - With DNN_FC_LAYER_SAT_EN → out=127.
  - Without → out=0x00.
  - -960, RELU=0 → -128 with the macro, 0x40 without.

Source files
------------

// File: rtl/dnn_fc_layer_seq_if.sv
// Bus bundle for dnn_fc_layer_seq: weight write port, input-vector
// handshake, result-vector handshake and busy status.
// master = upstream/controller side, slave = the layer itself.
interface dnn_fc_layer_seq_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int IN_W  = 5,
    parameter int W_W   = 5,
    parameter int OUT_W = 12
);
    localparam int N_W = N_IN * N_OUT;
    localparam int AW  = (N_W > 1) ? $clog2(N_W) : 1;

    logic                      w_we;
    logic [AW-1:0]             w_addr;
    logic signed [W_W-1:0]     w_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_IN*IN_W-1:0]      in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [N_OUT*OUT_W-1:0]    out_data;
    logic                      busy;

    modport master (
        output w_we, w_addr, w_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  w_we, w_addr, w_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/dnn_fc_layer_seq.sv
// Time-multiplexed fully-connected layer: one signed MAC per clock,
// N_IN*N_OUT MAC cycles per vector, runtime-writable weight store.
// Optional build macro DNN_FC_LAYER_SAT_EN: when defined, each result is
// saturated into the signed OUT_W range (only matters when OUT_W < ACC_W);
// when undefined the result wraps to its low OUT_W bits.
module dnn_fc_layer_seq #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int IN_W  = 5,
    parameter int W_W   = 5,
    parameter int ACC_W = IN_W + W_W + $clog2(N_IN),
    parameter int OUT_W = ACC_W,
    parameter int RELU  = 1
) (
    input  logic               clk,
    input  logic               rst,
    dnn_fc_layer_seq_if.slave  bus
);
    localparam int N_W = N_IN * N_OUT;
    localparam int AW  = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int PW  = IN_W + W_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [IW-1:0]           i_q, i_d;
    logic [JW-1:0]           j_q, j_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [N_IN*IN_W-1:0]    x_q, x_d;
    logic signed [OUT_W-1:0] res_q [N_OUT];
    logic signed [OUT_W-1:0] res_d [N_OUT];
    logic signed [W_W-1:0]   w_q [N_W];
    logic signed [W_W-1:0]   w_d [N_W];

    logic [AW-1:0]           rd_idx;
    logic signed [IN_W-1:0]  x_sel;
    logic signed [W_W-1:0]   w_sel;
    logic signed [PW-1:0]    prod_full;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] act;
    logic signed [OUT_W-1:0] res_val;
    logic [N_OUT*OUT_W-1:0]  out_pack;

    // MAC datapath: select x[i] and w[j*N_IN+i], multiply, accumulate, activate
    always_comb begin
        rd_idx    = AW'(int'(j_q) * N_IN + int'(i_q));
        x_sel     = $signed(x_q[int'(i_q)*IN_W +: IN_W]);
        w_sel     = w_q[rd_idx];
        prod_full = x_sel * w_sel;
        prod_ext  = ACC_W'(prod_full);
        sum       = acc_q + prod_ext;
        act       = ((RELU != 0) && (sum < 0)) ? '0 : sum;
    end

    // Reduce the activated accumulator to the output element width
    generate
        if (OUT_W >= ACC_W) begin : g_ext
            assign res_val = OUT_W'(act);
        end else begin : g_red
`ifdef DNN_FC_LAYER_SAT_EN
            localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
            localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
            // Clamp into the signed OUT_W range before narrowing
            always_comb begin
                if (act > SAT_MAX)
                    res_val = SAT_MAX[OUT_W-1:0];
                else if (act < SAT_MIN)
                    res_val = SAT_MIN[OUT_W-1:0];
                else
                    res_val = act[OUT_W-1:0];
            end
`else
            assign res_val = act[OUT_W-1:0];
`endif
        end
    endgenerate

    // Weight store next-state: writes only land while idle; addresses past
    // the store never match an entry and are dropped
    always_comb begin
        for (int k = 0; k < N_W; k++) begin
            w_d[k] = w_q[k];
            if (bus.w_we && (state_q == ST_IDLE) && (bus.w_addr == AW'(k)))
                w_d[k] = bus.w_data;
        end
    end

    // Control FSM next-state: accept a vector, sweep (j,i), hold results until taken
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        x_d     = x_q;
        for (int k = 0; k < N_OUT; k++)
            res_d[k] = res_q[k];

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.in_data;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (i_q == IW'(N_IN - 1)) begin
                    res_d[j_q] = res_val;
                    acc_d      = '0;
                    i_d        = '0;
                    if (j_q == JW'(N_OUT - 1))
                        state_d = ST_DONE;
                    else
                        j_d = j_q + 1'b1;
                end else begin
                    acc_d = sum;
                    i_d   = i_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and weight registers; reset also wipes the weights
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            for (int k = 0; k < N_OUT; k++)
                res_q[k] <= '0;
            for (int k = 0; k < N_W; k++)
                w_q[k] <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            for (int k = 0; k < N_OUT; k++)
                res_q[k] <= res_d[k];
            for (int k = 0; k < N_W; k++)
                w_q[k] <= w_d[k];
        end
    end

    // Pack per-neuron results into the output bus
    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pack
            assign out_pack[gi*OUT_W +: OUT_W] = res_q[gi];
        end
    endgenerate

    assign bus.out_data  = out_pack;
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dnn_fc_layer_seq.sv
// Bench for dnn_fc_layer_seq: three instances share one stimulus stream
// (RELU=1/OUT_W=12, RELU=0/OUT_W=12, RELU=0/OUT_W=8). Table vectors with
// hand-derived expectations, hand sequences for backpressure and reset,
// then random vectors against an arithmetic reference model.
module tb_dnn_fc_layer_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              w_we;
    logic [3:0]        w_addr;
    logic signed [4:0] w_data;
    logic              in_valid;
    logic [19:0]       in_data;
    logic              out_ready;

    dnn_fc_layer_seq_if #(.N_IN(4), .N_OUT(4), .IN_W(5), .W_W(5), .OUT_W(12)) if_a ();
    dnn_fc_layer_seq_if #(.N_IN(4), .N_OUT(4), .IN_W(5), .W_W(5), .OUT_W(12)) if_b ();
    dnn_fc_layer_seq_if #(.N_IN(4), .N_OUT(4), .IN_W(5), .W_W(5), .OUT_W(8))  if_c ();

    assign if_a.w_we = w_we;  assign if_a.w_addr = w_addr;  assign if_a.w_data = w_data;
    assign if_a.in_valid = in_valid;  assign if_a.in_data = in_data;  assign if_a.out_ready = out_ready;
    assign if_b.w_we = w_we;  assign if_b.w_addr = w_addr;  assign if_b.w_data = w_data;
    assign if_b.in_valid = in_valid;  assign if_b.in_data = in_data;  assign if_b.out_ready = out_ready;
    assign if_c.w_we = w_we;  assign if_c.w_addr = w_addr;  assign if_c.w_data = w_data;
    assign if_c.in_valid = in_valid;  assign if_c.in_data = in_data;  assign if_c.out_ready = out_ready;

    dnn_fc_layer_seq #(.RELU(1))              dut_a (.clk(clk), .rst(rst), .bus(if_a));
    dnn_fc_layer_seq #(.RELU(0))              dut_b (.clk(clk), .rst(rst), .bus(if_b));
    dnn_fc_layer_seq #(.OUT_W(8), .RELU(0))   dut_c (.clk(clk), .rst(rst), .bus(if_c));

    int n_vec = 0;
    int n_mis = 0;
    int wm [16];

    typedef struct {
        int wn0;
        int wrest;
        int x   [4];
        int ea  [4];
        int eb  [4];
        int ecs [4];
        int ecw [4];
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic logic [47:0] pack12(input int v [4]);
        logic [47:0] p;
        for (int j = 0; j < 4; j++) p[j*12 +: 12] = 12'(v[j]);
        return p;
    endfunction

    function automatic logic [31:0] pack8(input int v [4]);
        logic [31:0] p;
        for (int j = 0; j < 4; j++) p[j*8 +: 8] = 8'(v[j]);
        return p;
    endfunction

    function automatic logic [19:0] pack_x(input int v [4]);
        logic [19:0] p;
        for (int i = 0; i < 4; i++) p[i*5 +: 5] = 5'(v[i]);
        return p;
    endfunction

    // Reference: dot product, optional ReLU, then narrow to ow bits
    function automatic int model(input int xv [4], input int j, input int relu, input int ow);
        int s = 0;
        for (int i = 0; i < 4; i++) s += xv[i] * wm[j*4 + i];
        if (relu != 0 && s < 0) s = 0;
        if (ow < 12) begin
`ifdef DNN_FC_LAYER_SAT_EN
            if (s > (1 << (ow-1)) - 1) s = (1 << (ow-1)) - 1;
            else if (s < -(1 << (ow-1))) s = -(1 << (ow-1));
`else
            s = s & ((1 << ow) - 1);
            if (s >= (1 << (ow-1))) s -= (1 << ow);
`endif
        end
        return s;
    endfunction

    task automatic wr(input int addr, input int val);
        @(negedge clk);
        w_we = 1'b1; w_addr = 4'(addr); w_data = 5'(val);
        @(negedge clk);
        w_we = 1'b0;
        wm[addr] = val;
    endtask

    task automatic load_weights(input int n0, input int rest);
        for (int k = 0; k < 16; k++) wr(k, (k < 4) ? n0 : rest);
    endtask

    // Present one vector (optionally with a coincident weight write), wait for out_valid
    task automatic run_vec(input int xv [4], input string tag, input int wa, input int wv,
                           output logic [47:0] ra, output logic [47:0] rb, output logic [31:0] rc);
        int  n;
        bit  busy_ok;
        @(negedge clk);
        in_valid = 1'b1; in_data = pack_x(xv);
        if (wa >= 0) begin
            w_we = 1'b1; w_addr = 4'(wa); w_data = 5'(wv);
        end
        @(negedge clk);
        in_valid = 1'b0; w_we = 1'b0;
        if (wa >= 0) wm[wa] = wv;
        n = 0; busy_ok = 1'b1;
        while (!if_a.out_valid && n < 40) begin
            if (!if_a.busy || if_a.in_ready) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd16);
        chk({tag, "_busy"}, 64'(busy_ok && if_a.busy), 64'd1);
        ra = if_a.out_data; rb = if_b.out_data; rc = if_c.out_data;
        $display("vec %s lat=%0d a=%h b=%h c=%h", tag, n, ra, rb, rc);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 64'(if_a.out_valid), 64'd0);
        chk({tag, "_rel_ready"}, 64'(if_a.in_ready), 64'd1);
    endtask

    initial begin
        logic [47:0] ra, rb, ea, eb, hold;
        logic [31:0] rc, ec;
        int xv [4];
        int va [4], vb [4], vc [4];
        int zero4 [4];

        tbl[0] = '{wn0: 1,   wrest: 1,   x: '{1, 2, 3, 4},
                   ea: '{10, 10, 10, 10}, eb: '{10, 10, 10, 10},
                   ecs: '{10, 10, 10, 10}, ecw: '{10, 10, 10, 10}};
        tbl[1] = '{wn0: -1,  wrest: 1,   x: '{1, 2, 3, 4},
                   ea: '{0, 10, 10, 10}, eb: '{-10, 10, 10, 10},
                   ecs: '{-10, 10, 10, 10}, ecw: '{-10, 10, 10, 10}};
        tbl[2] = '{wn0: -16, wrest: -16, x: '{-16, -16, -16, -16},
                   ea: '{1024, 1024, 1024, 1024}, eb: '{1024, 1024, 1024, 1024},
                   ecs: '{127, 127, 127, 127}, ecw: '{0, 0, 0, 0}};
        tbl[3] = '{wn0: 15,  wrest: 15,  x: '{-16, -16, -16, -16},
                   ea: '{0, 0, 0, 0}, eb: '{-960, -960, -960, -960},
                   ecs: '{-128, -128, -128, -128}, ecw: '{64, 64, 64, 64}};
        zero4 = '{0, 0, 0, 0};
        for (int k = 0; k < 16; k++) wm[k] = 0;

        rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(if_a.in_ready), 64'd1);
        chk("rst_out_valid", 64'(if_a.out_valid), 64'd0);
        chk("rst_busy", 64'(if_a.busy), 64'd0);
        chk("rst_out_data", 64'(if_a.out_data), 64'd0);
        rst = 1'b0;

        // Table vectors with hand-derived expectations
        for (int t = 0; t < 4; t++) begin
            load_weights(tbl[t].wn0, tbl[t].wrest);
            run_vec(tbl[t].x, $sformatf("tbl%0d", t), -1, 0, ra, rb, rc);
            chk($sformatf("tbl%0d_a", t), 64'(ra), 64'(pack12(tbl[t].ea)));
            chk($sformatf("tbl%0d_b", t), 64'(rb), 64'(pack12(tbl[t].eb)));
`ifdef DNN_FC_LAYER_SAT_EN
            chk($sformatf("tbl%0d_c", t), 64'(rc), 64'(pack8(tbl[t].ecs)));
`else
            chk($sformatf("tbl%0d_c", t), 64'(rc), 64'(pack8(tbl[t].ecw)));
`endif
            release_out($sformatf("tbl%0d", t));
        end

        // Backpressure: results held, in_valid and w_we ignored while in DONE
        load_weights(1, 1);
        xv = '{1, 2, 3, 4};
        run_vec(xv, "bp", -1, 0, ra, rb, rc);
        hold = ra;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 20'($urandom);
            w_we = 1'b1; w_addr = 4'(c); w_data = 5'sd7;
            @(negedge clk);
            chk($sformatf("bp_hold%0d", c), 64'(if_a.out_data), 64'(hold));
            chk($sformatf("bp_ready%0d", c), 64'({if_a.in_ready, if_a.out_valid}), 64'b01);
        end
        in_valid = 1'b0; w_we = 1'b0;
        release_out("bp");
        run_vec(xv, "bp_after", -1, 0, ra, rb, rc);
        chk("bp_weights", 64'(ra), 64'(pack12(tbl[0].ea)));
        release_out("bp_after");

        // Reset during MAC: immediate idle, weights wiped
        @(negedge clk);
        in_valid = 1'b1; in_data = pack_x(xv);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy_before", 64'(if_a.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_flags", 64'({if_a.out_valid, if_a.busy, if_b.busy, if_c.busy}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) wm[k] = 0;
        chk("mid_rst_ready", 64'(if_a.in_ready), 64'd1);
        run_vec(xv, "post_rst", -1, 0, ra, rb, rc);
        chk("post_rst_a", 64'(ra), 64'(pack12(zero4)));
        chk("post_rst_c", 64'(rc), 64'(pack8(zero4)));
        release_out("post_rst");

        // Random vectors against the reference model, with a weight write on the accept edge
        for (int r = 0; r < 16; r++) begin
            int wa, wv;
            for (int k = 0; k < 16; k++) wr(k, int'($urandom_range(31)) - 16);
            for (int i = 0; i < 4; i++) xv[i] = int'($urandom_range(31)) - 16;
            wa = int'($urandom_range(15));
            wv = int'($urandom_range(31)) - 16;
            run_vec(xv, $sformatf("rnd%0d", r), wa, wv, ra, rb, rc);
            for (int j = 0; j < 4; j++) begin
                va[j] = model(xv, j, 1, 12);
                vb[j] = model(xv, j, 0, 12);
                vc[j] = model(xv, j, 0, 8);
            end
            ea = pack12(va); eb = pack12(vb); ec = pack8(vc);
            chk($sformatf("rnd%0d_a", r), 64'(ra), 64'(ea));
            chk($sformatf("rnd%0d_b", r), 64'(rb), 64'(eb));
            chk($sformatf("rnd%0d_c", r), 64'(rc), 64'(ec));
            release_out($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
